// File: rtl/ofm_write_data_sequencer_pkg.sv
// Shared definitions for the OFM write data sequencer.
//   - ofm_seq_state_e : drain FSM state encoding
//   - LeakyShift      : arithmetic right-shift applied to negative values in leaky ReLU mode
package ofm_write_data_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrain = 2'd1,
        StGap1  = 2'd2,
        StGap2  = 2'd3
    } ofm_seq_state_e;

    localparam int unsigned LeakyShift = 3;

endpackage

// File: rtl/ofm_write_data_sequencer_if.sv
// Row-in / OFM-out bus of the write data sequencer.
//   in_valid, in_data, in_last : one channel row offered by the systolic array (lane 0 in LSBs)
//   in_ready                   : sequencer accepts the offered row this cycle
//   write                      : one-cycle burst-start pulse to the OFM address controller
//   ofm_we, ofm_data           : OFM RAM write enable and processed channel row
// master = row producer / OFM consumer side, slave = sequencer side.
interface ofm_write_data_sequencer_if #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 16
);
    logic                                in_valid;
    logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0]  in_data;
    logic                                in_last;
    logic                                in_ready;
    logic                                write;
    logic                                ofm_we;
    logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] ofm_data;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, write, ofm_we, ofm_data
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, write, ofm_we, ofm_data
    );
endinterface

// File: rtl/ofm_postproc_lane.sv
// Per-lane OFM post-processing: round-half-up requantisation shift, optional leaky ReLU,
// saturation to DATA_WIDTH and lane masking. Purely combinational.
//   acc_i       : signed accumulator value
//   act_mode_i  : 0 linear, 1 leaky ReLU
//   out_shift_i : requantisation right-shift
//   lane_en_i   : lane is inside the valid OFM width; otherwise the output is zero
//   data_o      : signed OFM word
module ofm_postproc_lane
    import ofm_write_data_sequencer_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic                  act_mode_i,
    input  logic [4:0]            out_shift_i,
    input  logic                  lane_en_i,
    output logic [DATA_WIDTH-1:0] data_o
);
    // One guard bit so the rounding add cannot overflow.
    localparam int unsigned WideW = ACC_WIDTH + 1;
    localparam logic signed [WideW-1:0] SatMax = WideW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [WideW-1:0] SatMin = WideW'(-(2 ** (DATA_WIDTH - 1)));

    logic signed [WideW-1:0] acc_ext;
    logic signed [WideW-1:0] rnd;
    logic signed [WideW-1:0] scaled;
    logic signed [WideW-1:0] act_val;

    always_comb begin
        acc_ext = {acc_i[ACC_WIDTH-1], acc_i};
        rnd     = '0;
        if (out_shift_i != 5'd0) begin
            rnd = WideW'(1) << (out_shift_i - 5'd1);
        end
        scaled  = (acc_ext + rnd) >>> out_shift_i;
        act_val = scaled;
        if (act_mode_i && scaled[WideW-1]) begin
            act_val = scaled >>> LeakyShift;
        end

        if (!lane_en_i) begin
            data_o = '0;
        end else if (act_val > SatMax) begin
            data_o = SatMax[DATA_WIDTH-1:0];
        end else if (act_val < SatMin) begin
            data_o = SatMin[DATA_WIDTH-1:0];
        end else begin
            data_o = act_val[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ofm_write_data_sequencer.sv
// OFM write data sequencer: double-buffers channel rows from the systolic array into two
// banks and drains each full bank as a burst of post-processed rows to the OFM RAM.
//   clk, rst        : clock and synchronous active-high reset
//   bus (slave)     : row input handshake and OFM write outputs
//   act_mode        : 0 linear, 1 leaky ReLU (latched at burst start)
//   out_shift       : requantisation right-shift (latched at burst start)
//   write_ofm_size  : number of valid lanes 1..SYSTOLIC_SIZE (latched at burst start)
//   busy            : FSM not idle or a bank holds a complete tile
module ofm_write_data_sequencer
    import ofm_write_data_sequencer_pkg::*;
#(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    ofm_write_data_sequencer_if.slave        bus,
    input  logic                             act_mode,
    input  logic [4:0]                       out_shift,
    input  logic [4:0]                       write_ofm_size,
    output logic                             busy
);
    localparam int unsigned RowW    = SYSTOLIC_SIZE * ACC_WIDTH;
    localparam int unsigned OutW    = SYSTOLIC_SIZE * DATA_WIDTH;
    localparam int unsigned IdxW    = $clog2(SYSTOLIC_SIZE);
    localparam logic [4:0]  LastRow = 5'(SYSTOLIC_SIZE - 1);

    logic [RowW-1:0] bank_q [2][SYSTOLIC_SIZE];

    ofm_seq_state_e  state_q, state_d;
    logic            fill_ptr_q, fill_ptr_d;
    logic            drain_ptr_q, drain_ptr_d;
    logic [1:0]      bank_full_q, bank_full_d;
    logic [4:0]      rcnt_q, rcnt_d;
    logic [1:0][4:0] count_q, count_d;
    logic [4:0]      beat_q, beat_d;
    logic            act_mode_q, act_mode_d;
    logic [4:0]      out_shift_q, out_shift_d;
    logic [4:0]      size_q, size_d;
    logic            in_ready_q, in_ready_d;
    logic            write_q, write_d;
    logic            ofm_we_q, ofm_we_d;
    logic [OutW-1:0] ofm_data_q, ofm_data_d;

    logic            accept;
    logic            close_bank;
    logic            last_beat;
    logic [RowW-1:0] drain_row;
    logic [OutW-1:0] proc_row;

    assign drain_row = bank_q[drain_ptr_q][beat_q[IdxW-1:0]];

    for (genvar l = 0; l < SYSTOLIC_SIZE; l++) begin : g_lane
        ofm_postproc_lane #(
            .ACC_WIDTH (ACC_WIDTH),
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .acc_i      (drain_row[l*ACC_WIDTH +: ACC_WIDTH]),
            .act_mode_i (act_mode_q),
            .out_shift_i(out_shift_q),
            .lane_en_i  (5'(l) < size_q),
            .data_o     (proc_row[l*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        drain_ptr_d = drain_ptr_q;
        bank_full_d = bank_full_q;
        rcnt_d      = rcnt_q;
        count_d     = count_q;
        beat_d      = beat_q;
        act_mode_d  = act_mode_q;
        out_shift_d = out_shift_q;
        size_d      = size_q;
        write_d     = 1'b0;
        ofm_we_d    = 1'b0;
        ofm_data_d  = '0;

        accept     = bus.in_valid && in_ready_q;
        close_bank = accept && (bus.in_last || (rcnt_q == LastRow));
        last_beat  = (state_q == StDrain) && (beat_q == count_q[drain_ptr_q] - 5'd1);

        // Fill side: independent of the drain FSM so both banks can be busy at once.
        if (accept) begin
            rcnt_d = rcnt_q + 5'd1;
            if (close_bank) begin
                bank_full_d[fill_ptr_q] = 1'b1;
                count_d[fill_ptr_q]     = rcnt_q + 5'd1;
                fill_ptr_d              = !fill_ptr_q;
                rcnt_d                  = '0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (bank_full_q[drain_ptr_q]) begin
                    state_d     = StDrain;
                    beat_d      = '0;
                    act_mode_d  = act_mode;
                    out_shift_d = out_shift;
                    size_d      = write_ofm_size;
                end
            end
            StDrain: begin
                write_d    = (beat_q == 5'd0);
                ofm_we_d   = 1'b1;
                ofm_data_d = proc_row;
                if (last_beat) begin
                    bank_full_d[drain_ptr_q] = 1'b0;
                    drain_ptr_d              = !drain_ptr_q;
                    state_d                  = StGap1;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            // Two dead cycles let the address controller finish its base update.
            StGap1:  state_d = StGap2;
            StGap2:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Look at next-state occupancy so a row is never offered into a bank just closed.
        in_ready_d = !bank_full_d[fill_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fill_ptr_q  <= 1'b0;
            drain_ptr_q <= 1'b0;
            bank_full_q <= 2'b00;
            rcnt_q      <= '0;
            count_q     <= '0;
            beat_q      <= '0;
            act_mode_q  <= 1'b0;
            out_shift_q <= '0;
            size_q      <= '0;
            in_ready_q  <= 1'b1;
            write_q     <= 1'b0;
            ofm_we_q    <= 1'b0;
            ofm_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            fill_ptr_q  <= fill_ptr_d;
            drain_ptr_q <= drain_ptr_d;
            bank_full_q <= bank_full_d;
            rcnt_q      <= rcnt_d;
            count_q     <= count_d;
            beat_q      <= beat_d;
            act_mode_q  <= act_mode_d;
            out_shift_q <= out_shift_d;
            size_q      <= size_d;
            in_ready_q  <= in_ready_d;
            write_q     <= write_d;
            ofm_we_q    <= ofm_we_d;
            ofm_data_q  <= ofm_data_d;
        end
    end

    // Row storage carries no reset; stale contents are never read without a fresh fill.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            bank_q[fill_ptr_q][rcnt_q[IdxW-1:0]] <= bus.in_data;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.write    = write_q;
    assign bus.ofm_we   = ofm_we_q;
    assign bus.ofm_data = ofm_data_q;
    assign busy         = (state_q != StIdle) || (bank_full_q != 2'b00);

endmodule

// File: tb/tb_ofm_write_data_sequencer.sv
module tb_ofm_write_data_sequencer;
    localparam int unsigned SS = 16;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned IW = SS * AW;
    localparam int unsigned OW = SS * DW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       act_mode = 1'b0;
    logic [4:0] out_shift = 5'd0;
    logic [4:0] write_ofm_size = 5'd16;
    logic       busy;

    always #5 clk = ~clk;

    ofm_write_data_sequencer_if #(
        .SYSTOLIC_SIZE(SS),
        .ACC_WIDTH    (AW),
        .DATA_WIDTH   (DW)
    ) bus ();

    ofm_write_data_sequencer #(
        .SYSTOLIC_SIZE(SS),
        .ACC_WIDTH    (AW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .act_mode      (act_mode),
        .out_shift     (out_shift),
        .write_ofm_size(write_ofm_size),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int idle_nz  = 0;
    int stalls   = 0;

    logic [OW-1:0] got_q[$];
    int            we_cyc_q[$];
    int            wr_cyc_q[$];

    task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (bus.ofm_we === 1'b1) begin
            got_q.push_back(bus.ofm_data);
            we_cyc_q.push_back(cyc);
        end else if (bus.ofm_data !== '0) begin
            idle_nz++;
        end
        if (bus.write === 1'b1) wr_cyc_q.push_back(cyc);
    end

    function automatic logic [IW-1:0] in_row(input int base, input int r);
        logic [IW-1:0] v;
        v = '0;
        for (int l = 0; l < SS; l++) v[l*AW +: AW] = AW'(base + r * 16 + l);
        return v;
    endfunction

    // Linear mode, shift 0, small positive values: output equals input, masked lanes zero.
    function automatic logic [OW-1:0] out_row(input int base, input int r, input int size);
        logic [OW-1:0] v;
        v = '0;
        for (int l = 0; l < SS; l++) if (l < size) v[l*DW +: DW] = DW'(base + r * 16 + l);
        return v;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        we_cyc_q.delete();
        wr_cyc_q.delete();
        stalls = 0;
    endtask

    // Called at posedge+1; holds the row until it is seen accepted.
    task automatic drive_row(input logic [IW-1:0] row, input logic last);
        logic rdy;
        int   waited;
        rdy = 1'b0;
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = row;
        bus.in_last  = last;
        while (!rdy && waited < 200) begin
            @(negedge clk);
            rdy = bus.in_ready;
            if (!rdy) stalls++;
            @(posedge clk);
            #1;
            waited++;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!rdy) check("in_ready_timeout", OW'(0), OW'(1));
    endtask

    task automatic send_stream(input int ntiles, input int nrows, input int base0);
        for (int t = 0; t < ntiles; t++)
            for (int r = 0; r < nrows; r++)
                drive_row(in_row(base0 + t * 4096, r), r == nrows - 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (got_q.size() < n) check("beat_timeout", OW'(got_q.size()), OW'(n));
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_reached", OW'(busy), OW'(0));
    endtask

    task automatic check_tile(input string tag, input int n, input int base, input int size);
        check({tag, "_beats"}, OW'(got_q.size()), OW'(n));
        check({tag, "_writes"}, OW'(wr_cyc_q.size()), OW'(1));
        for (int i = 0; i < n && i < got_q.size(); i++)
            check($sformatf("%s_row%0d", tag, i), got_q[i], out_row(base, i, size));
        if (got_q.size() == n) begin
            check({tag, "_consecutive"}, OW'(we_cyc_q[n-1] - we_cyc_q[0]), OW'(n - 1));
            if (wr_cyc_q.size() > 0)
                check({tag, "_write_on_beat0"}, OW'(wr_cyc_q[0]), OW'(we_cyc_q[0]));
        end
    endtask

    task automatic run_single(input string tag, input logic [IW-1:0] row,
                              input logic [OW-1:0] exp);
        clear_mon();
        drive_row(row, 1'b1);
        wait_beats(1, 50);
        wait_idle(50);
        check({tag, "_beats"}, OW'(got_q.size()), OW'(1));
        if (got_q.size() > 0) check({tag, "_data"}, got_q[0], exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [IW-1:0] row;
        logic [OW-1:0] exp;
        logic [31:0]   va[5];
        logic [15:0]   ea[5];
        int            n_before;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst_ofm_we", OW'(bus.ofm_we), OW'(0));
        check("rst_write", OW'(bus.write), OW'(0));
        check("rst_ofm_data", bus.ofm_data, OW'(0));
        check("rst_busy", OW'(busy), OW'(0));
        check("rst_in_ready", OW'(bus.in_ready), OW'(1));

        // Full 16-row tile, identity processing.
        clear_mon();
        send_stream(1, 16, 0);
        wait_beats(16, 100);
        repeat (4) @(posedge clk);
        #1;
        check_tile("t1", 16, 0, 16);
        wait_idle(50);

        // Leaky ReLU with rounding shift 2.
        act_mode = 1'b1; out_shift = 5'd2; write_ofm_size = 5'd16;
        va = '{32'hFFFF_FCE0, 32'd6, 32'hFFFF_FFFF, 32'd1000, 32'hFFFF_FFF9};
        ea = '{16'hFFE7, 16'h0002, 16'h0000, 16'h00FA, 16'hFFFF};
        row = '0; exp = '0;
        for (int l = 0; l < 5; l++) begin row[l*AW +: AW] = va[l]; exp[l*DW +: DW] = ea[l]; end
        run_single("t2a", row, exp);
        if (got_q.size() > 0) check("t2a_lane0_m25", OW'(got_q[0][15:0]), OW'(16'hFFE7));

        // Saturation, linear, shift 0.
        act_mode = 1'b0; out_shift = 5'd0; write_ofm_size = 5'd16;
        va = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB, 32'h0001_0000, 32'h0000_0012};
        ea = '{16'h7FFF, 16'h8000, 16'hFFFB, 16'h7FFF, 16'h0012};
        row = '0; exp = '0;
        for (int l = 0; l < 5; l++) begin row[l*AW +: AW] = va[l]; exp[l*DW +: DW] = ea[l]; end
        run_single("t2b", row, exp);

        // Rounding shift 4 with only 3 valid lanes.
        act_mode = 1'b0; out_shift = 5'd4; write_ofm_size = 5'd3;
        va = '{32'd24, 32'd23, 32'hFFFF_FFE8, 32'd100, 32'd0};
        ea = '{16'h0002, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000};
        row = '0; exp = '0;
        for (int l = 0; l < 5; l++) begin row[l*AW +: AW] = va[l]; exp[l*DW +: DW] = ea[l]; end
        run_single("t2c", row, exp);

        // 13-row tile, 13 valid lanes.
        act_mode = 1'b0; out_shift = 5'd0; write_ofm_size = 5'd13;
        clear_mon();
        send_stream(1, 13, 0);
        wait_beats(13, 100);
        repeat (4) @(posedge clk);
        #1;
        check_tile("t3", 13, 0, 13);
        wait_idle(50);

        // Three tiles back-to-back.
        write_ofm_size = 5'd16;
        clear_mon();
        send_stream(3, 16, 4096);
        check("t4_in_ready_stall", OW'(stalls > 0), OW'(1));
        wait_beats(48, 300);
        wait_idle(100);
        check("t4_beats", OW'(got_q.size()), OW'(48));
        check("t4_writes", OW'(wr_cyc_q.size()), OW'(3));
        for (int i = 0; i < 48 && i < got_q.size(); i++)
            check($sformatf("t4_row%0d", i), got_q[i], out_row(4096 + (i / 16) * 4096, i % 16, 16));
        for (int i = 1; i < wr_cyc_q.size(); i++)
            check($sformatf("t4_write_gap%0d", i), OW'((wr_cyc_q[i] - wr_cyc_q[i-1]) >= 18), OW'(1));

        // Reset on beat 5 of a drain.
        clear_mon();
        send_stream(1, 16, 16384);
        n_before = 0;
        while (got_q.size() < 5 && n_before < 100) begin
            @(posedge clk);
            #1;
            n_before++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t5_beats_before_rst", OW'(got_q.size()), OW'(6));
        check("t5_busy_after_rst", OW'(busy), OW'(0));
        check("t5_in_ready_after_rst", OW'(bus.in_ready), OW'(1));
        clear_mon();
        send_stream(1, 16, 24576);
        wait_beats(16, 100);
        repeat (4) @(posedge clk);
        #1;
        check_tile("t5", 16, 24576, 16);
        wait_idle(50);

        check("ofm_data_zero_when_idle", OW'(idle_nz), OW'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ofm_write_data_sequencer.md
OFM_WRITE_DATA_SEQUENCER -- requirements
Module: ofm_write_data_sequencer

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, meaning the number of pixel lanes per row and the maximum number of channel rows per tile.
REQ-002 SHALL have parameter ACC_WIDTH, default 32, meaning the signed accumulator width per lane from the systolic array.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, meaning the signed OFM word width per lane.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: one channel row is offered on in_data.
REQ-007 SHALL have port in_data, input, SYSTOLIC_SIZE*ACC_WIDTH bits: one channel row; lane 0 is in the LSBs.
REQ-008 SHALL have port in_last, input, 1 bit: the current row is the tile's last channel row.
REQ-009 SHALL have port in_ready, output, 1 bit: the sequencer accepts a row this cycle.
REQ-010 SHALL have port act_mode, input, 1 bit: 0 selects linear, 1 selects leaky ReLU.
REQ-011 SHALL have port out_shift, input, 5 bits: the requantisation right-shift.
REQ-012 SHALL have port write_ofm_size, input, 5 bits: the number of valid lanes, 1..SYSTOLIC_SIZE.
REQ-013 SHALL have port write, output, 1 bit: a one-cycle burst-start pulse to the OFM write address controller.
REQ-014 SHALL have port ofm_we, output, 1 bit: the OFM RAM write enable, one beat per channel.
REQ-015 SHALL have port ofm_data, output, SYSTOLIC_SIZE*DATA_WIDTH bits: the processed channel row.
REQ-016 SHALL have port busy, output, 1 bit: high when state != IDLE or any bank is full.

Function
REQ-017 SHALL hold two row banks (0, 1), each of SYSTOLIC_SIZE rows x SYSTOLIC_SIZE lanes x ACC_WIDTH, with fill_ptr, drain_ptr, bank_full[1:0] and a per-bank row count of 5 bits.
REQ-018 SHALL accept a row when in_valid && in_ready, write it at row index rcnt of bank fill_ptr, and increment rcnt.
REQ-019 SHALL close a bank when the accepted row has in_last=1 or rcnt reaches SYSTOLIC_SIZE-1: set bank_full, store count = rcnt+1, toggle fill_ptr, and clear rcnt.
REQ-020 SHALL register in_ready as !bank_full[fill_ptr] as of the next state, so no row is accepted into a full bank.
REQ-021 SHALL implement FSM states IDLE, DRAIN, GAP1, GAP2 with transitions: IDLE->DRAIN when bank_full[drain_ptr]; DRAIN->GAP1 after beat count-1; GAP1->GAP2; GAP2->IDLE.
REQ-022 SHALL, in DRAIN, emit beat k = 0..count-1 on consecutive cycles: registered ofm_we=1 and ofm_data = processed row k; write=1 on beat 0 only.
REQ-023 SHALL, on the final beat, clear bank_full[drain_ptr] and toggle drain_ptr at that edge.
REQ-024 SHALL keep the GAP1/GAP2 idle cycles fixed, so the address controller completes UPDATE_BASE_ADDR and returns to IDLE before the next write.
REQ-025 SHALL process each lane as follows:
- y = (x + (1<<(out_shift-1))) >>> out_shift, with no rounding term when out_shift=0;
- if act_mode=1 and y<0, then y = y >>> 3;
- saturate y to signed DATA_WIDTH.
REQ-026 SHALL force lanes >= write_ofm_size to zero.
REQ-027 SHALL sample act_mode, out_shift and write_ofm_size on the IDLE->DRAIN edge and hold them for the burst.
REQ-028 SHALL allow filling one bank while the other drains in the same cycle.
REQ-029 SHALL keep each beat's ofm_data value driven only while ofm_we=1; otherwise ofm_data holds zero.

Reset
REQ-030 SHALL, on rst, set: state=IDLE, fill_ptr=drain_ptr=0, bank_full=0, rcnt=0, write=0, ofm_we=0, ofm_data=0, busy=0, in_ready=1 on the following cycle.
REQ-031 SHALL drop any partially filled or draining bank on reset mid-burst, with no further ofm_we beats; bank contents need no reset.

Structure
REQ-032 SHALL place the FSM state encodings and the leaky shift constant (3) in the shared accelerator package.
REQ-033 SHALL use one sub-module, ofm_postproc_lane (round, shift, leaky, saturate, mask), instantiated SYSTOLIC_SIZE times.

Verification
REQ-034 SHALL cover: 16 rows with in_last on row 15, act_mode=0, out_shift=0, values 0..15 -> write on beat 0, 16 consecutive ofm_we beats, data equal to input, then 2 idle cycles.
REQ-035 SHALL cover: lane value -800, act_mode=1, out_shift=2 -> -200 >>> 3 = -25; lane value 0x7FFF_FFFF, out_shift=0 -> 0x7FFF.
REQ-036 SHALL cover: 13-row tile with in_last on row 12 and write_ofm_size=13 -> 13 beats, lanes 13..15 equal 0.
REQ-037 SHALL cover: three tiles offered back-to-back with continuous in_valid -> in_ready low after two tiles until the first drain ends, no row lost or duplicated, and consecutive write pulses spaced >= count+2 cycles.
REQ-038 SHALL cover: rst asserted on beat 5 of a drain -> ofm_we low from the next cycle, then the next tile drains from bank 0 with correct data.
